// File: rtl/hazard_pkg.sv
// Shared definitions for the multi-cycle hazard/forwarding controller.
//   hz_state_t : stall-timing FSM states
//   CNT_W      : latency down-counter width (latencies up to 16)
//   RES_LOAD   : ResultSrc encoding that marks a load
//   FWD_*      : ForwardAE/ForwardBE operand-source encodings
package hazard_pkg;

  localparam int CNT_W = $clog2(16);

  typedef enum logic [2:0] {
    IDLE,
    MEM_WAIT,
    MDU_WAIT,
    REL_MEM,
    REL_MDU
  } hz_state_t;

  localparam logic [1:0] RES_LOAD = 2'b01;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

endpackage

// File: rtl/hazard_lat_counter.sv
// Loadable down-counter shared by the memory and MDU stall timers.
//   clk, rst_n : clock, synchronous active-low reset (count -> 0)
//   load, val  : load val this cycle (load wins over dec)
//   dec        : decrement by one, saturating at zero
//   zero       : count is zero
module hazard_lat_counter #(
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [CW-1:0] val,
  input  logic          dec,
  output logic          zero
);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= val;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/hazard_unit_mc.sv
// Hazard/forwarding controller for the 5-stage RV32 pipeline with a
// multi-cycle data memory (MEM_LAT) and multi-cycle MDU (MDU_LAT).
//   Rs1D/Rs2D, Rs1E/Rs2E/RdE, RdM, RdW : register indices per stage
//   RegWriteE/M/W, ResultSrcE/M        : write enables, result source
//   MduE, PCSrcE                       : MDU op in E, taken redirect
//   StallF/D/E/M, FlushD/E/M/W         : per-stage hold / bubble
//   ForwardAE/BE                       : E operand source select
//   Busy                               : registered FSM-not-idle
module hazard_unit_mc
  import hazard_pkg::*;
#(
  parameter int AW      = 5,
  parameter int MEM_LAT = 1,
  parameter int MDU_LAT = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] Rs1D,
  input  logic [AW-1:0] Rs2D,
  input  logic [AW-1:0] Rs1E,
  input  logic [AW-1:0] Rs2E,
  input  logic [AW-1:0] RdE,
  input  logic [AW-1:0] RdM,
  input  logic [AW-1:0] RdW,
  input  logic          RegWriteE,
  input  logic          RegWriteM,
  input  logic          RegWriteW,
  input  logic [1:0]    ResultSrcE,
  input  logic [1:0]    ResultSrcM,
  input  logic          MduE,
  input  logic [1:0]    PCSrcE,
  output logic          StallF,
  output logic          StallD,
  output logic          StallE,
  output logic          StallM,
  output logic          FlushD,
  output logic          FlushE,
  output logic          FlushM,
  output logic          FlushW,
  output logic [1:0]    ForwardAE,
  output logic [1:0]    ForwardBE,
  output logic          Busy
);

  // The trigger cycle is one stall cycle and the WAIT state covers the
  // rest, so the counter holds (remaining WAIT cycles - 1).
  localparam logic [CNT_W-1:0] MEM_LOAD = (MEM_LAT > 2) ? CNT_W'(MEM_LAT - 3) : '0;
  localparam logic [CNT_W-1:0] MDU_LOAD = (MDU_LAT > 2) ? CNT_W'(MDU_LAT - 3) : '0;

  function automatic logic [1:0] fwd_sel(input logic [AW-1:0] rs,
                                         input logic [AW-1:0] rd_m,
                                         input logic          we_m,
                                         input logic [AW-1:0] rd_w,
                                         input logic          we_w);
    if (rs != '0 && rs == rd_m && we_m)      return FWD_M;
    else if (rs != '0 && rs == rd_w && we_w) return FWD_W;
    else                                     return FWD_RF;
  endfunction

  hz_state_t        state, state_n;
  logic             cnt_load, cnt_dec, cnt_zero;
  logic [CNT_W-1:0] cnt_val;
  logic             mem_go, mdu_go, start_mem, start_mdu;
  logic             mem_stall, mdu_stall, e_stall;
  logic             load_use, redirect;

  assign mem_go = (ResultSrcM == RES_LOAD) && (MEM_LAT > 1);
  assign mdu_go = MduE && (MDU_LAT > 1);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n   = state;
    start_mem = 1'b0;
    start_mdu = 1'b0;
    mem_stall = 1'b0;
    mdu_stall = 1'b0;
    cnt_load  = 1'b0;
    cnt_dec   = 1'b0;
    cnt_val   = '0;
    case (state)
      IDLE: begin
        if (mem_go)      start_mem = 1'b1;
        else if (mdu_go) start_mdu = 1'b1;
      end
      REL_MEM: begin
        state_n = IDLE;
        if (mdu_go) start_mdu = 1'b1;
      end
      REL_MDU: begin
        state_n = IDLE;
        if (mem_go) start_mem = 1'b1;
      end
      MEM_WAIT: begin
        mem_stall = 1'b1;
        if (cnt_zero) state_n = REL_MEM;
        else          cnt_dec = 1'b1;
      end
      MDU_WAIT: begin
        mdu_stall = 1'b1;
        if (cnt_zero) state_n = REL_MDU;
        else          cnt_dec = 1'b1;
      end
      default: state_n = IDLE;
    endcase
    // Trigger cycle already stalls combinationally; a two-cycle latency
    // needs no WAIT state and goes straight to release.
    if (start_mem) begin
      mem_stall = 1'b1;
      cnt_load  = 1'b1;
      cnt_val   = MEM_LOAD;
      state_n   = (MEM_LAT == 2) ? REL_MEM : MEM_WAIT;
    end else if (start_mdu) begin
      mdu_stall = 1'b1;
      cnt_load  = 1'b1;
      cnt_val   = MDU_LOAD;
      state_n   = (MDU_LAT == 2) ? REL_MDU : MDU_WAIT;
    end
  end

  hazard_lat_counter #(.CW(CNT_W)) u_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (cnt_load),
    .val   (cnt_val),
    .dec   (cnt_dec),
    .zero  (cnt_zero)
  );

  assign e_stall  = mem_stall || mdu_stall;
  assign load_use = !e_stall && (ResultSrcE == RES_LOAD) && RegWriteE &&
                    (RdE != '0) && ((RdE == Rs1D) || (RdE == Rs2D));
  // A redirect while E is held would flush the wrong instructions, so it
  // waits until E moves again.
  assign redirect = !e_stall && (PCSrcE != 2'b00);

  always_comb begin
    StallF    = 1'b0;
    StallD    = 1'b0;
    StallE    = 1'b0;
    StallM    = 1'b0;
    FlushD    = 1'b0;
    FlushE    = 1'b0;
    FlushM    = 1'b0;
    FlushW    = 1'b0;
    ForwardAE = FWD_RF;
    ForwardBE = FWD_RF;
    Busy      = 1'b0;
    if (rst_n) begin
      StallF    = e_stall || (load_use && !redirect);
      StallD    = e_stall || (load_use && !redirect);
      StallE    = e_stall;
      StallM    = mem_stall;
      FlushD    = redirect;
      FlushE    = redirect || load_use;
      FlushM    = mdu_stall;
      FlushW    = mem_stall;
      ForwardAE = fwd_sel(Rs1E, RdM, RegWriteM, RdW, RegWriteW);
      ForwardBE = fwd_sel(Rs2E, RdM, RegWriteM, RdW, RegWriteW);
      Busy      = (state != IDLE);
    end
  end

endmodule

// File: tb/tb_hazard_unit_mc.sv
// Directed bench for hazard_unit_mc. Two instances share inputs:
// A with MEM_LAT=3/MDU_LAT=4, B with MEM_LAT=2/MDU_LAT=3.
// Observed outputs are packed as
// {StallF,StallD,StallE,StallM,FlushD,FlushE,FlushM,FlushW,FwdA,FwdB,Busy}.
module tb_hazard_unit_mc;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic       RegWriteE, RegWriteM, RegWriteW, MduE;
  logic [1:0] ResultSrcE, ResultSrcM, PCSrcE;

  logic       a_sf, a_sd, a_se, a_sm, a_fd, a_fe, a_fm, a_fw, a_bz;
  logic       b_sf, b_sd, b_se, b_sm, b_fd, b_fe, b_fm, b_fw, b_bz;
  logic [1:0] a_fa, a_fb, b_fa, b_fb;
  logic [12:0] obs_a, obs_b;

  int unsigned n_pass = 0;
  int unsigned n_total = 0;

  localparam logic [12:0] ZERO = 13'b0;
  localparam logic [12:0] BZ   = 13'b0000000000001;
  localparam logic [12:0] MEMS = 13'b1111000100000;
  localparam logic [12:0] MDUS = 13'b1110001000000;
  localparam logic [12:0] LU   = 13'b1100010000000;
  localparam logic [12:0] RD   = 13'b0000110000000;

  always #5 clk = ~clk;

  hazard_unit_mc #(.AW(5), .MEM_LAT(3), .MDU_LAT(4)) u_dut_a (
    .clk(clk), .rst_n(rst_n),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
    .RdM(RdM), .RdW(RdW),
    .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .ResultSrcE(ResultSrcE), .ResultSrcM(ResultSrcM),
    .MduE(MduE), .PCSrcE(PCSrcE),
    .StallF(a_sf), .StallD(a_sd), .StallE(a_se), .StallM(a_sm),
    .FlushD(a_fd), .FlushE(a_fe), .FlushM(a_fm), .FlushW(a_fw),
    .ForwardAE(a_fa), .ForwardBE(a_fb), .Busy(a_bz)
  );

  hazard_unit_mc #(.AW(5), .MEM_LAT(2), .MDU_LAT(3)) u_dut_b (
    .clk(clk), .rst_n(rst_n),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
    .RdM(RdM), .RdW(RdW),
    .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .ResultSrcE(ResultSrcE), .ResultSrcM(ResultSrcM),
    .MduE(MduE), .PCSrcE(PCSrcE),
    .StallF(b_sf), .StallD(b_sd), .StallE(b_se), .StallM(b_sm),
    .FlushD(b_fd), .FlushE(b_fe), .FlushM(b_fm), .FlushW(b_fw),
    .ForwardAE(b_fa), .ForwardBE(b_fb), .Busy(b_bz)
  );

  assign obs_a = {a_sf, a_sd, a_se, a_sm, a_fd, a_fe, a_fm, a_fw, a_fa, a_fb, a_bz};
  assign obs_b = {b_sf, b_sd, b_se, b_sm, b_fd, b_fe, b_fm, b_fw, b_fa, b_fb, b_bz};

  typedef struct {
    string      name;
    logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
    logic       rwe, rwm, rww;
    logic [1:0] rse, pcs;
    logic [12:0] exp;
  } vec_t;

  vec_t tbl[11];

  function automatic vec_t mkv(input string nm,
                               input logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw,
                               input logic rwe, rwm, rww,
                               input logic [1:0] rse, pcs,
                               input logic [12:0] exp);
    vec_t v;
    v.name = nm;
    v.rs1d = rs1d; v.rs2d = rs2d; v.rs1e = rs1e; v.rs2e = rs2e;
    v.rde = rde; v.rdm = rdm; v.rdw = rdw;
    v.rwe = rwe; v.rwm = rwm; v.rww = rww;
    v.rse = rse; v.pcs = pcs; v.exp = exp;
    return v;
  endfunction

  function automatic logic [12:0] fw(input logic [1:0] a, input logic [1:0] b);
    return {8'b0, a, b, 1'b0};
  endfunction

  task automatic chk(input string nm, input logic [12:0] act, input logic [12:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b", nm, act, exp);
  endtask

  task automatic clear_in();
    Rs1D = '0; Rs2D = '0; Rs1E = '0; Rs2E = '0; RdE = '0; RdM = '0; RdW = '0;
    RegWriteE = 1'b0; RegWriteM = 1'b0; RegWriteW = 1'b0;
    ResultSrcE = 2'b00; ResultSrcM = 2'b00; MduE = 1'b0; PCSrcE = 2'b00;
  endtask

  task automatic do_reset();
    clear_in();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic apply_vec(input vec_t v);
    Rs1D = v.rs1d; Rs2D = v.rs2d; Rs1E = v.rs1e; Rs2E = v.rs2e;
    RdE = v.rde; RdM = v.rdm; RdW = v.rdw;
    RegWriteE = v.rwe; RegWriteM = v.rwm; RegWriteW = v.rww;
    ResultSrcE = v.rse; PCSrcE = v.pcs;
    ResultSrcM = 2'b00; MduE = 1'b0;
  endtask

  initial begin
    //               name       rs1d rs2d rs1e rs2e rde rdm rdw rwe rwm rww rse    pcs    exp
    tbl[0]  = mkv("quiet",      0,   0,   0,   0,   0,  0,  0,  0,  0,  0,  2'b00, 2'b00, ZERO);
    tbl[1]  = mkv("fwd_m_prio", 0,   0,   7,   4,   0,  7,  7,  0,  1,  1,  2'b00, 2'b00, fw(2'b10, 2'b00));
    tbl[2]  = mkv("fwd_x0",     0,   0,   0,   0,   0,  0,  0,  0,  1,  1,  2'b00, 2'b00, ZERO);
    tbl[3]  = mkv("fwd_w",      0,   0,   7,   4,   0,  7,  7,  0,  0,  1,  2'b00, 2'b00, fw(2'b01, 2'b00));
    tbl[4]  = mkv("fwd_both_m", 0,   0,   12,  12,  0,  12, 12, 0,  1,  1,  2'b00, 2'b00, fw(2'b10, 2'b10));
    tbl[5]  = mkv("load_use",   0,   5,   0,   0,   5,  0,  0,  1,  0,  0,  2'b01, 2'b00, LU);
    tbl[6]  = mkv("lu_redir",   0,   5,   0,   0,   5,  0,  0,  1,  0,  0,  2'b01, 2'b01, RD);
    tbl[7]  = mkv("lu_rd0",     0,   0,   0,   0,   0,  0,  0,  1,  0,  0,  2'b01, 2'b00, ZERO);
    tbl[8]  = mkv("lu_notload", 5,   0,   0,   0,   5,  0,  0,  1,  0,  0,  2'b00, 2'b00, ZERO);
    tbl[9]  = mkv("lu_nowrite", 5,   0,   0,   0,   5,  0,  0,  0,  0,  0,  2'b01, 2'b00, ZERO);
    tbl[10] = mkv("redir_only", 0,   0,   0,   0,   0,  0,  0,  0,  0,  0,  2'b00, 2'b10, RD);

    // Reset holds every output low even with triggering/forwarding inputs.
    clear_in();
    rst_n = 1'b0;
    Rs1E = 5'd7; RdM = 5'd7; RegWriteM = 1'b1; MduE = 1'b1; ResultSrcM = 2'b01; PCSrcE = 2'b01;
    #1;
    chk("rst_a", obs_a, ZERO);
    chk("rst_b", obs_b, ZERO);
    @(negedge clk);
    @(negedge clk);
    clear_in();
    rst_n = 1'b1;
    #1;
    chk("idle_a", obs_a, ZERO);
    chk("idle_b", obs_b, ZERO);
    @(negedge clk);

    for (int i = 0; i < 11; i++) begin
      apply_vec(tbl[i]);
      #1;
      chk({tbl[i].name, "_a"}, obs_a, tbl[i].exp);
      chk({tbl[i].name, "_b"}, obs_b, tbl[i].exp);
      @(negedge clk);
    end
    clear_in();
    @(negedge clk);

    // Load held in M: A stalls two cycles then releases; B (latency 2)
    // stalls one cycle, releases, and retriggers on the still-present load.
    ResultSrcM = 2'b01;
    #1; chk("mem_t0_a", obs_a, MEMS);      chk("mem_t0_b", obs_b, MEMS);
    @(negedge clk);
    #1; chk("mem_t1_a", obs_a, MEMS | BZ); chk("mem_t1_b", obs_b, BZ);
    @(negedge clk);
    #1; chk("mem_t2_a", obs_a, BZ);        chk("mem_t2_b", obs_b, MEMS);
    @(negedge clk);
    ResultSrcM = 2'b00;
    #1; chk("mem_t3_a", obs_a, ZERO);      chk("mem_t3_b", obs_b, BZ);
    @(negedge clk);
    #1; chk("mem_t4_a", obs_a, ZERO);      chk("mem_t4_b", obs_b, ZERO);

    // MDU on A: three stall cycles with deferred redirect and masked
    // load-use, one release, retrigger, then reset mid-stall.
    do_reset();
    MduE = 1'b1;
    #1; chk("mdu_t0", obs_a, MDUS);
    @(negedge clk);
    PCSrcE = 2'b01;
    #1; chk("mdu_t1_redir_defer", obs_a, MDUS | BZ);
    @(negedge clk);
    PCSrcE = 2'b00;
    ResultSrcE = 2'b01; RegWriteE = 1'b1; RdE = 5'd5; Rs1D = 5'd5;
    #1; chk("mdu_t2_lu_masked", obs_a, MDUS | BZ);
    @(negedge clk);
    clear_in();
    MduE = 1'b1;
    #1; chk("mdu_t3_release", obs_a, BZ);
    @(negedge clk);
    #1; chk("mdu_t4_retrig", obs_a, MDUS);
    @(negedge clk);
    rst_n = 1'b0;
    Rs1E = 5'd7; RdM = 5'd7; RegWriteM = 1'b1;
    #1; chk("mdu_rst_low", obs_a, ZERO);
    @(negedge clk);
    rst_n = 1'b1;
    clear_in();
    #1; chk("mdu_rst_after", obs_a, ZERO);
    @(negedge clk);
    #1; chk("mdu_rst_idle", obs_a, ZERO);

    // B: load and MDU together; memory first, MDU starts from REL_MEM.
    do_reset();
    ResultSrcM = 2'b01; MduE = 1'b1;
    #1; chk("both_t0", obs_b, MEMS);
    @(negedge clk);
    ResultSrcM = 2'b00;
    #1; chk("both_t1", obs_b, MDUS | BZ);
    @(negedge clk);
    #1; chk("both_t2", obs_b, MDUS | BZ);
    @(negedge clk);
    MduE = 1'b0;
    #1; chk("both_t3", obs_b, BZ);
    @(negedge clk);
    #1; chk("both_t4", obs_b, ZERO);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
